// File: rtl/input_conditioner_pkg.sv
// Shared sizes and default timing for the board input conditioner.
package input_conditioner_pkg;

  localparam int unsigned NUM_BUTTONS        = 4;
  localparam int unsigned NUM_SWITCHES       = 16;
  localparam int unsigned DEF_TICK_DIV       = 100000;
  localparam int unsigned DEF_STABLE_SAMPLES = 10;
  localparam int unsigned DEF_REPEAT_SAMPLES = 250;
  localparam int unsigned CNT_W              = 4;

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One raw input bit: 2-flop synchroniser, tick-sampled debounce, registered edge flags.
module input_conditioner_debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic tick_i,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic             sync0_q, sync1_q;
  logic             level_q, level_d;
  logic             rise_q, fall_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A disagreeing sample must persist STABLE_SAMPLES ticks; any agreeing tick restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick_i) begin
      if (sync1_q != level_q) begin
        if (cnt_q == CNT_W'(STABLE_SAMPLES - 1)) begin
          level_d = sync1_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync0_q <= 1'b0;
      sync1_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync0_q <= raw_i;
      sync1_q <= sync0_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounces buttons and switches and emits armed, single-cycle press/toggle pulses.
// Optional button auto-repeat is enabled by defining INPUT_COND_AUTOREPEAT_EN.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned TICK_DIV       = DEF_TICK_DIV,
  parameter int unsigned STABLE_SAMPLES = DEF_STABLE_SAMPLES,
  parameter int unsigned REPEAT_SAMPLES = DEF_REPEAT_SAMPLES
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic [NUM_BUTTONS-1:0]  buttons_i,
  input  logic [NUM_SWITCHES-1:0] switches_i,
  output logic [NUM_BUTTONS-1:0]  buttons_level_o,
  output logic [NUM_BUTTONS-1:0]  buttons_press_o,
  output logic [NUM_SWITCHES-1:0] switches_level_o,
  output logic [NUM_SWITCHES-1:0] switches_toggle_o,
  output logic                    any_toggle_o,
  output logic                    armed_o
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned ARM_W = $clog2(STABLE_SAMPLES + 2);

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic                    tick_c;
  logic [ARM_W-1:0]        arm_q, arm_d;
  logic                    armed_q, armed_d;
  logic [NUM_BUTTONS-1:0]  btn_level_c, btn_rise_c, btn_fall_unused;
  logic [NUM_SWITCHES-1:0] sw_level_c, sw_rise_c, sw_fall_c;
  logic [NUM_BUTTONS-1:0]  rep_fire_c;
  logic [NUM_BUTTONS-1:0]  press_q, press_d;
  logic [NUM_SWITCHES-1:0] toggle_q, toggle_d;

  assign tick_c = (pre_q == PRE_W'(TICK_DIV - 1));

  // Prescaler wraps; arming counter saturates so armed stays high until reset.
  always_comb begin
    pre_d   = tick_c ? '0 : pre_q + PRE_W'(1);
    arm_d   = arm_q;
    armed_d = armed_q | (arm_q == ARM_W'(STABLE_SAMPLES + 1));
    if (tick_c && (arm_q != ARM_W'(STABLE_SAMPLES + 1))) begin
      arm_d = arm_q + ARM_W'(1);
    end
    press_d  = armed_q ? (btn_rise_c | rep_fire_c) : '0;
    toggle_d = armed_q ? (sw_rise_c | sw_fall_c) : '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pre_q    <= '0;
      arm_q    <= '0;
      armed_q  <= 1'b0;
      press_q  <= '0;
      toggle_q <= '0;
    end else begin
      pre_q    <= pre_d;
      arm_q    <= arm_d;
      armed_q  <= armed_d;
      press_q  <= press_d;
      toggle_q <= toggle_d;
    end
  end

  for (genvar n = 0; n < NUM_BUTTONS; n++) begin : g_btn
    input_conditioner_debounce_channel #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_chan (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .tick_i  (tick_c),
      .raw_i   (buttons_i[n]),
      .level_o (btn_level_c[n]),
      .rise_o  (btn_rise_c[n]),
      .fall_o  (btn_fall_unused[n])
    );
  end

  for (genvar n = 0; n < NUM_SWITCHES; n++) begin : g_sw
    input_conditioner_debounce_channel #(.STABLE_SAMPLES(STABLE_SAMPLES)) u_chan (
      .clock_i (clock_i),
      .reset_i (reset_i),
      .tick_i  (tick_c),
      .raw_i   (switches_i[n]),
      .level_o (sw_level_c[n]),
      .rise_o  (sw_rise_c[n]),
      .fall_o  (sw_fall_c[n])
    );
  end

`ifdef INPUT_COND_AUTOREPEAT_EN
  localparam int unsigned REP_W = 8;

  logic [NUM_BUTTONS-1:0][REP_W-1:0] rep_q, rep_d;
  logic [NUM_BUTTONS-1:0]            rep_init_q, rep_init_d;

  // First period of REPEAT_SAMPLES ticks only sets the init flag, giving a 2x initial delay.
  always_comb begin
    rep_d      = rep_q;
    rep_init_d = rep_init_q;
    rep_fire_c = '0;
    for (int n = 0; n < int'(NUM_BUTTONS); n++) begin
      if (!btn_level_c[n]) begin
        rep_d[n]      = '0;
        rep_init_d[n] = 1'b0;
      end else if (tick_c && armed_q) begin
        if (rep_q[n] == REP_W'(REPEAT_SAMPLES - 1)) begin
          rep_d[n]      = '0;
          rep_init_d[n] = 1'b1;
          rep_fire_c[n] = rep_init_q[n];
        end else begin
          rep_d[n] = rep_q[n] + REP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      rep_q      <= '0;
      rep_init_q <= '0;
    end else begin
      rep_q      <= rep_d;
      rep_init_q <= rep_init_d;
    end
  end
`else
  logic unused_repeat_c;
  assign unused_repeat_c = ^REPEAT_SAMPLES;
  assign rep_fire_c      = '0;
`endif

  assign buttons_level_o   = btn_level_c;
  assign buttons_press_o   = press_q;
  assign switches_level_o  = sw_level_c;
  assign switches_toggle_o = toggle_q;
  assign any_toggle_o      = |toggle_q;
  assign armed_o           = armed_q;

endmodule
